syn_m_multi: RTL and testbench



---
 rtl/syn_m_multi.sv | 221 ++++++++++++++++++++++
 tb/tb_syn_m_multi.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_m_multi.sv
// syn_m_multi: GPS-disciplined master sync generator driving NCH channel-masked RS-485 bursts.
// Optional build macro SYN_M_MEAS_EN enables the GPS period measurement on gps_period.
module syn_m_multi #(
    parameter int NCH       = 4,
    parameter int PERIOD_US = 1000000,
    parameter int WIN_US    = 100,
    parameter int PW_US     = 10,
    parameter int GUARD_US  = 2,
    parameter int MISS_MAX  = 3,
    parameter int CW        = 21
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic           pluse_us,
    input  logic           syn_en,
    input  logic [NCH-1:0] ch_en,
    input  logic           gps_pluse,
    output logic [NCH-1:0] tx_ctrl,
    output logic [NCH-1:0] tx_syn,
    output logic           lock,
    output logic           busy,
    output logic [15:0]    syn_cnt,
    output logic [CW-1:0]  gps_period
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_HOLD} state_t;
    typedef enum logic [1:0] {PH_OFF, PH_LEAD, PH_SYN, PH_LAG} phase_t;

    localparam logic [CW-1:0] LO_TH   = CW'(PERIOD_US - WIN_US);
    localparam logic [CW-1:0] HI_TH   = CW'(PERIOD_US + WIN_US);
    localparam logic [CW-1:0] PER_TH  = CW'(PERIOD_US);
    localparam logic [15:0]   GD_END  = 16'(GUARD_US - 1);
    localparam logic [15:0]   PW_END  = 16'(PW_US - 1);
    localparam logic [7:0]    MISS_TH = 8'(MISS_MAX);

    state_t         state;
    phase_t         phase;
    logic           gps_p0, gps_p1, gps_p2, gps_edge;
    logic [CW-1:0]  us_cnt;
    logic [7:0]     miss;
    logic [15:0]    ph_cnt;
    logic [NCH-1:0] mask;
    logic           trig, acc, fly;

    // Stage p0/p1: two-flop synchroniser; p2 + gps_edge: registered rising-edge detect
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            gps_p0   <= 1'b0;
            gps_p1   <= 1'b0;
            gps_p2   <= 1'b0;
            gps_edge <= 1'b0;
        end else begin
            gps_p0   <= gps_pluse;
            gps_p1   <= gps_p0;
            gps_p2   <= gps_p1;
            gps_edge <= gps_p1 & ~gps_p2;
        end
    end

    // trig: any trigger this cycle; acc: GPS edge accepted in LOCK/HOLD; fly: flywheel trigger
    always_comb begin
        trig = 1'b0;
        acc  = 1'b0;
        fly  = 1'b0;
        if (syn_en) begin
            case (state)
                ST_IDLE: trig = gps_edge;
                ST_LOCK: begin
                    if (gps_edge && (us_cnt >= LO_TH)) begin
                        trig = 1'b1;
                        acc  = 1'b1;
                    end else if (us_cnt >= HI_TH) begin
                        trig = 1'b1;
                        fly  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (gps_edge) begin
                        trig = 1'b1;
                        acc  = 1'b1;
                    end else if (us_cnt >= PER_TH) begin
                        trig = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            phase   <= PH_OFF;
            us_cnt  <= '0;
            miss    <= '0;
            ph_cnt  <= '0;
            mask    <= '0;
            tx_ctrl <= '0;
            tx_syn  <= '0;
            busy    <= 1'b0;
            syn_cnt <= '0;
        end else begin
            // Cleared on every trigger, including dropped ones, to stay aligned to GPS
            if (trig) begin
                us_cnt <= '0;
            end else if (pluse_us && (us_cnt != '1)) begin
                us_cnt <= us_cnt + CW'(1);
            end

            if (!syn_en) begin
                state   <= ST_IDLE;
                miss    <= '0;
                phase   <= PH_OFF;
                ph_cnt  <= '0;
                busy    <= 1'b0;
                tx_ctrl <= '0;
                tx_syn  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trig) begin
                            state <= ST_LOCK;
                            miss  <= '0;
                        end
                    end
                    ST_LOCK: begin
                        if (acc) begin
                            miss <= '0;
                        end else if (fly) begin
                            miss <= miss + 8'd1;
                            if ((miss + 8'd1) >= MISS_TH) begin
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (acc) begin
                            state <= ST_LOCK;
                            miss  <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase

                // The trigger cycle's own tick never counts toward the first phase
                if (trig && !busy) begin
                    mask    <= ch_en;
                    busy    <= 1'b1;
                    syn_cnt <= syn_cnt + 16'd1;
                    ph_cnt  <= '0;
                    tx_ctrl <= ch_en;
                    if (GUARD_US == 0) begin
                        phase  <= PH_SYN;
                        tx_syn <= ch_en;
                    end else begin
                        phase  <= PH_LEAD;
                        tx_syn <= '0;
                    end
                end else if (busy && pluse_us) begin
                    case (phase)
                        PH_LEAD: begin
                            if (ph_cnt == GD_END) begin
                                phase  <= PH_SYN;
                                tx_syn <= mask;
                                ph_cnt <= '0;
                            end else begin
                                ph_cnt <= ph_cnt + 16'd1;
                            end
                        end
                        PH_SYN: begin
                            if (ph_cnt == PW_END) begin
                                ph_cnt <= '0;
                                tx_syn <= '0;
                                if (GUARD_US == 0) begin
                                    phase   <= PH_OFF;
                                    tx_ctrl <= '0;
                                    busy    <= 1'b0;
                                end else begin
                                    phase <= PH_LAG;
                                end
                            end else begin
                                ph_cnt <= ph_cnt + 16'd1;
                            end
                        end
                        PH_LAG: begin
                            if (ph_cnt == GD_END) begin
                                ph_cnt  <= '0;
                                phase   <= PH_OFF;
                                tx_ctrl <= '0;
                                busy    <= 1'b0;
                            end else begin
                                ph_cnt <= ph_cnt + 16'd1;
                            end
                        end
                        default: begin
                            phase   <= PH_OFF;
                            tx_ctrl <= '0;
                            tx_syn  <= '0;
                            busy    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign lock = (state == ST_LOCK);

`ifdef SYN_M_MEAS_EN
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            gps_period <= '0;
        end else if (acc) begin
            gps_period <= us_cnt;
        end
    end
`else
    assign gps_period = '0;
`endif

endmodule

// File: tb/tb_syn_m_multi.sv
// Bench for syn_m_multi: directed vector table, multi-cycle corner sequences and a randomized
// GPS-event run checked against a microsecond-level model of lock/flywheel/holdover behaviour.
`timescale 1ns/1ps
module tb_syn_m_multi;
    localparam int NCH = 4, PERIOD = 100, WIN = 5, PW = 3, GUARD = 2, MISSM = 2, CW = 21;
    localparam int BLEN = 2 * GUARD + PW;

    logic           clk_sys = 1'b0;
    logic           rst_n = 1'b0;
    logic           pluse_us = 1'b0;
    logic           syn_en = 1'b0;
    logic           gps_pluse = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] tx_ctrl, tx_syn;
    logic           lock, busy;
    logic [15:0]    syn_cnt;
    logic [CW-1:0]  gps_period;

    syn_m_multi #(.NCH(NCH), .PERIOD_US(PERIOD), .WIN_US(WIN), .PW_US(PW), .GUARD_US(GUARD),
                  .MISS_MAX(MISSM), .CW(CW)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us), .syn_en(syn_en), .ch_en(ch_en),
        .gps_pluse(gps_pluse), .tx_ctrl(tx_ctrl), .tx_syn(tx_syn), .lock(lock), .busy(busy),
        .syn_cnt(syn_cnt), .gps_period(gps_period));

    always #5 clk_sys = ~clk_sys;

    int   checks = 0;
    int   errors = 0;
    int   ticks = 0;
    int   cyc = 0;
    event tick_ev;

    typedef struct {
        logic [NCH-1:0] mask;
        logic [NCH-1:0] smask;
        int r, sr, sf, f;
    } brec_t;
    brec_t bq[$];

    typedef struct {
        int             gap;
        logic [NCH-1:0] ch;
        bit             trig;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Burst monitor and pluse_us generator; ticks = microsecond ticks consumed by the DUT so far
    initial begin
        brec_t          cur;
        logic [NCH-1:0] pc, ps;
        pc = '0; ps = '0;
        cur = '{mask: '0, smask: '0, r: -1, sr: -1, sf: -1, f: -1};
        forever begin
            @(negedge clk_sys);
            if (pc == 0 && tx_ctrl != 0) begin
                cur = '{mask: tx_ctrl, smask: '0, r: ticks, sr: -1, sf: -1, f: -1};
            end
            if (ps == 0 && tx_syn != 0) begin
                cur.sr = ticks;
                cur.smask = tx_syn;
            end
            if (ps != 0 && tx_syn == 0) cur.sf = ticks;
            if (pc != 0 && tx_ctrl == 0) begin
                cur.f = ticks;
                bq.push_back(cur);
            end
            pc = tx_ctrl;
            ps = tx_syn;
            cyc++;
            pluse_us = (cyc % 4 == 0);
            if (pluse_us) begin
                ticks++;
                -> tick_ev;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_tick(input int a);
        if (ticks >= a) begin
            checks++;
            errors++;
            $display("FAIL sched: tick %0d already passed target %0d", ticks, a);
        end
        while (ticks < a) @(tick_ev);
    endtask

    task automatic gps_at(input int a);
        wait_tick(a);
        gps_pluse = 1'b1;
        repeat (3) @(negedge clk_sys);
        gps_pluse = 1'b0;
    endtask

    task automatic pop_burst(input string nm, input logic [NCH-1:0] m, input int r);
        brec_t b;
        chk($sformatf("%s seen", nm), bq.size() > 0, 1);
        if (bq.size() > 0) begin
            b = bq.pop_front();
            chk($sformatf("%s mask", nm), b.mask, m);
            chk($sformatf("%s syn mask", nm), b.smask, m);
            chk($sformatf("%s rise tick", nm), b.r, r);
            chk($sformatf("%s lead", nm), b.sr - b.r, GUARD);
            chk($sformatf("%s syn width", nm), b.sf - b.sr, PW);
            chk($sformatf("%s ctrl width", nm), b.f - b.r, BLEN);
        end
    endtask

    task automatic chk_period(input string nm, input int d);
`ifdef SYN_M_MEAS_EN
        chk(nm, gps_period, d);
`else
        chk(nm, gps_period, (d == 0) ? 0 : 0);
`endif
    endtask

    initial begin
        vec_t        vt[7];
        int          last, a, h, per_exp;
        logic [15:0] exp_cnt;
        int          m_last, m_miss;
        bit          m_hold;

        vt[0] = '{100, 4'b0011, 1'b1};
        vt[1] = '{50,  4'b1111, 1'b0};
        vt[2] = '{100, 4'b1010, 1'b1};
        vt[3] = '{95,  4'b0110, 1'b1};
        vt[4] = '{94,  4'b1001, 1'b0};
        vt[5] = '{104, 4'b0000, 1'b1};
        vt[6] = '{98,  4'b1100, 1'b1};
        exp_cnt = '0;
        per_exp = 0;

        repeat (5) @(negedge clk_sys);
        chk("rst tx_ctrl", tx_ctrl, 0);
        chk("rst tx_syn", tx_syn, 0);
        chk("rst lock", lock, 0);
        chk("rst busy", busy, 0);
        chk("rst syn_cnt", syn_cnt, 0);
        chk("rst gps_period", gps_period, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_sys);

        // First lock from IDLE and the 4-cycle trigger latency
        syn_en = 1'b1;
        ch_en = 4'b0101;
        a = ticks + 2;
        wait_tick(a);
        gps_pluse = 1'b1;
        repeat (3) @(negedge clk_sys);
        gps_pluse = 1'b0;
        chk("lat3 tx_ctrl", tx_ctrl, 0);
        @(negedge clk_sys);
        chk("lat4 tx_ctrl", tx_ctrl, 4'b0101);
        chk("lat4 busy", busy, 1);
        chk("lat4 lock", lock, 1);
        exp_cnt++;
        chk("lat4 syn_cnt", syn_cnt, exp_cnt);
        last = a;
        wait_tick(last + BLEN + 1);
        pop_burst("first", 4'b0101, last);
        chk("first busy end", busy, 0);
        chk_period("first period", per_exp);

        // Table: GPS edge offsets from the last trigger, including window boundaries and a 0 mask
        for (int i = 0; i < 7; i++) begin
            ch_en = vt[i].ch;
            a = last + vt[i].gap;
            gps_at(a);
            wait_tick(a + (vt[i].trig ? BLEN + 1 : 2));
            if (vt[i].trig) begin
                exp_cnt++;
                per_exp = vt[i].gap;
                if (vt[i].ch != 0) pop_burst($sformatf("vec%0d", i), vt[i].ch, a);
                last = a;
            end
            chk($sformatf("vec%0d syn_cnt", i), syn_cnt, exp_cnt);
            chk($sformatf("vec%0d lock", i), lock, 1);
            chk($sformatf("vec%0d extra bursts", i), bq.size(), 0);
            chk_period($sformatf("vec%0d period", i), per_exp);
        end

        // Flywheel twice, holdover, dropped trigger while busy, then re-acquire
        ch_en = 4'b0011;
        wait_tick(last + PERIOD + WIN + BLEN + 1);
        pop_burst("fly1", 4'b0011, last + PERIOD + WIN);
        exp_cnt++;
        chk("fly1 lock", lock, 1);
        last += PERIOD + WIN;
        wait_tick(last + PERIOD + WIN + BLEN + 1);
        pop_burst("fly2", 4'b0011, last + PERIOD + WIN);
        exp_cnt++;
        chk("fly2 lock", lock, 0);
        chk("fly2 syn_cnt", syn_cnt, exp_cnt);
        last += PERIOD + WIN;
        h = last + PERIOD;
        gps_at(h + 3);
        wait_tick(h + 5);
        exp_cnt++;
        per_exp = 3;
        chk("drop lock", lock, 1);
        chk("drop busy", busy, 1);
        chk("drop syn_cnt", syn_cnt, exp_cnt);
        chk_period("drop period", per_exp);
        wait_tick(h + BLEN + 1);
        pop_burst("hold1", 4'b0011, h);
        last = h + 3;
        wait_tick(last + PERIOD + WIN + BLEN + 1);
        pop_burst("fly3", 4'b0011, last + PERIOD + WIN);
        exp_cnt++;
        last += PERIOD + WIN;
        wait_tick(last + PERIOD + WIN + BLEN + 1);
        pop_burst("fly4", 4'b0011, last + PERIOD + WIN);
        exp_cnt++;
        chk("fly4 lock", lock, 0);
        last += PERIOD + WIN;
        ch_en = 4'b1110;
        wait_tick(last + PERIOD + BLEN + 1);
        pop_burst("hold2", 4'b1110, last + PERIOD);
        exp_cnt++;
        last += PERIOD;
        a = last + 40;
        gps_at(a);
        wait_tick(a + BLEN + 1);
        pop_burst("reacq", 4'b1110, a);
        exp_cnt++;
        per_exp = 40;
        chk("reacq lock", lock, 1);
        chk("reacq syn_cnt", syn_cnt, exp_cnt);
        chk_period("reacq period", per_exp);
        last = a;

        // syn_en dropped in the SYN phase aborts the burst immediately
        ch_en = 4'b0101;
        a = last + PERIOD;
        gps_at(a);
        wait_tick(a + GUARD + 1);
        chk("pre-drop tx_syn", tx_syn, 4'b0101);
        syn_en = 1'b0;
        @(negedge clk_sys);
        exp_cnt++;
        chk("abort tx_ctrl", tx_ctrl, 0);
        chk("abort tx_syn", tx_syn, 0);
        chk("abort busy", busy, 0);
        chk("abort lock", lock, 0);
        chk("abort syn_cnt", syn_cnt, exp_cnt);
        bq.delete();
        a = ticks + 2;
        gps_at(a);
        wait_tick(a + 3);
        chk("disabled syn_cnt", syn_cnt, exp_cnt);
        chk("disabled tx_ctrl", tx_ctrl, 0);
        syn_en = 1'b1;
        a = ticks + 2;
        gps_at(a);
        wait_tick(a + BLEN + 1);
        pop_burst("restart", 4'b0101, a);
        exp_cnt++;
        chk("restart lock", lock, 1);
        chk_period("restart period", per_exp);
        last = a;

        // ch_en change mid-burst, then syn_cnt wrap
        a = last + PERIOD;
        gps_at(a);
        wait_tick(a + 3);
        ch_en = 4'b1111;
        wait_tick(a + BLEN + 1);
        pop_burst("midchg", 4'b0101, a);
        last = a;
        force dut.syn_cnt = 16'hFFFF;
        @(negedge clk_sys);
        release dut.syn_cnt;
        @(negedge clk_sys);
        chk("preset syn_cnt", syn_cnt, 16'hFFFF);
        exp_cnt = 16'hFFFF;
        a = last + PERIOD;
        gps_at(a);
        wait_tick(a + BLEN + 1);
        exp_cnt++;
        pop_burst("wrap", 4'b1111, a);
        chk("wrap syn_cnt", syn_cnt, exp_cnt);
        last = a;

        // Randomized GPS events against the microsecond-level model
        m_last = last;
        m_miss = 0;
        m_hold = 1'b0;
        for (int k = 0; k < 40; k++) begin
            int             r, d, dmin, dmax, t;
            logic [NCH-1:0] c;
            c = NCH'($urandom_range(1, 15));
            ch_en = c;
            r = $urandom_range(0, 3);
            dmin = ticks - m_last + 1;
            dmax = m_hold ? PERIOD - 1 : PERIOD + WIN - 1;
            if (r == 0 || dmin > dmax) begin
                t = m_last + (m_hold ? PERIOD : PERIOD + WIN);
                if (!m_hold) begin
                    m_miss++;
                    if (m_miss >= MISSM) m_hold = 1'b1;
                end
                wait_tick(t + BLEN + 1);
                exp_cnt++;
                pop_burst($sformatf("rnd%0d auto", k), c, t);
                m_last = t;
            end else begin
                d = $urandom_range(dmin, dmax);
                t = m_last + d;
                gps_at(t);
                if (m_hold || d >= PERIOD - WIN) begin
                    m_hold = 1'b0;
                    m_miss = 0;
                    per_exp = d;
                    wait_tick(t + BLEN + 1);
                    exp_cnt++;
                    pop_burst($sformatf("rnd%0d gps", k), c, t);
                    m_last = t;
                end else begin
                    wait_tick(t + 2);
                end
            end
            chk($sformatf("rnd%0d syn_cnt", k), syn_cnt, exp_cnt);
            chk($sformatf("rnd%0d lock", k), lock, !m_hold);
            chk($sformatf("rnd%0d extra bursts", k), bq.size(), 0);
            chk_period($sformatf("rnd%0d period", k), per_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
